normcoef_calc: RTL and testbench
================================

Name: normcoef_calc

Overview:
- Sequential gain-calibration block that produces the unsigned normalizing coefficient (1.0 = 0x8000) consumed by the channel normalizing multiplier.
- From a measured signed pulse amplitude and an unsigned target amplitude it computes coef = floor(target * 2^15 / amp) with an iterative restoring divider.
- Holds the result in an output register. The host may also load that register directly.
- Sits between the channel amplitude-measurement logic / host registers and the multiplier's coefficient input.

Parameters:
- COEF_RESET, 16'h8000, coef value after reset (unity gain).
- MIN_AMP, 16, amplitudes below this value (signed compare) are rejected as error.

Ports:
- clk  input  1  master clock, 125 MHz
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to compute; sampled only in IDLE
- amp  input  16  measured amplitude, signed two's complement, sampled with start
- target  input  16  desired amplitude, unsigned, sampled with start
- coef_wr  input  1  host direct write strobe
- coef_wdat  input  16  host direct write data
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  one-cycle pulse when a computation finishes, including error and saturated cases
- sat  output  1  sticky flag for the last computation: quotient clipped to 0xFFFF
- err  output  1  sticky flag for the last computation: amp < MIN_AMP, coef not updated
- coef  output  16  coefficient register, unsigned, 1.0 = 0x8000

Behaviour:
- Reset (rst_n low, asynchronous):
  - coef = COEF_RESET; busy = done = sat = err = 0; state = IDLE.
  - Reset mid-computation aborts the computation with no done pulse.
- States: IDLE, CHECK, DIV, DONE.
- IDLE:
  - If start = 1, latch amp and target, clear sat and err, and go to CHECK.
  - If coef_wr = 1, coef <= coef_wdat and start is ignored that cycle (write wins).
- CHECK (one cycle):
  - If signed amp < MIN_AMP: set err, go to DONE.
  - Else if target >= 2*amp (quotient would be >= 2^16): set sat, go to DONE.
  - Else load the divider (dividend = target << 15, divisor = amp[14:0]), clear the iteration counter, go to DIV.
- DIV:
  - Exactly 16 cycles, one quotient bit per cycle, MSB first, restoring.
  - Remainder width 17 bits; no quotient bit is lost because of the CHECK precondition.
  - After the 16th bit, go to DONE.
- DONE (one cycle):
  - done = 1.
  - coef <= quotient if the computation was normal; coef <= 16'hFFFF if sat; coef unchanged if err.
  - Next state IDLE.
- Latency (start sampled at edge t):
  - Normal: done high during the cycle after edge t+18, and coef holds the new value in that same cycle.
  - Err / sat: done after edge t+2.
- busy is high in CHECK, DIV and DONE, and low in IDLE.
- Rounding: truncation toward zero; the remainder is discarded.
- Simultaneous and overlapping events:
  - start while busy: ignored, not queued.
  - coef_wr while busy: coef <= coef_wdat immediately, the computation is aborted to IDLE, no done pulse, sat and err cleared.
  - coef_wr in DONE: the write wins over the computed result, no done pulse.
- amp and target may change after start; the latched copies are used.
- sat and err hold until the next accepted start, a coef_wr, or reset.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-cycle -> coef = 0x8000 and busy/done/sat/err = 0 immediately; release and idle 10 cycles -> outputs stable.
- Unity and fractional results, checking done exactly 18 cycles after start:
  - target = 0x1000, amp = 0x1000 -> coef = 0x8000, sat = err = 0.
  - target = 0x0C00, amp = 0x1000 -> coef = 0x6000.
  - target = 1000, amp = 3000 -> coef = 0x2AAA (truncated).
- Saturation and error paths, each with done 2 cycles after start:
  - target = 0x1000, amp = 0x0800 -> coef = 0xFFFF, sat = 1.
  - amp = 0x0000 -> err = 1, coef unchanged.
  - amp = 0xF000 (negative) -> err = 1, coef unchanged.
  - amp = 15 with MIN_AMP = 16 -> err = 1, coef unchanged.
- Busy handling: start asserted during DIV with different operands -> ignored, first result delivered unchanged; coef_wr = 0x1234 during DIV -> coef = 0x1234 next cycle, no done, busy low.
- Write/start collision in IDLE: coef_wr = 0x4000 and start in the same cycle -> coef = 0x4000, busy stays 0, no done.
- Randomized sweep of 1000 operand pairs against a reference model floor(target * 32768 / amp) with clip and err rules -> bit-exact coef, sat, err and latency.

Source files
------------

// File: rtl/normcoef_calc.sv
// Gain-calibration coefficient unit: coef = floor(target * 2^15 / amp), computed with a
// 16-step restoring divider, with saturation, error rejection and a host override.
module normcoef_calc #(
   parameter logic [15:0] COEF_RESET = 16'h8000,
   parameter int          MIN_AMP    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] amp,
   input  logic [15:0] target,
   input  logic        coef_wr,
   input  logic [15:0] coef_wdat,
   output logic        busy,
   output logic        done,
   output logic        sat,
   output logic        err,
   output logic [15:0] coef
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] DIV   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic signed [15:0] MIN_AMP_S = 16'(MIN_AMP);

   logic [1:0]  state;
   logic [15:0] amp_q;
   logic [15:0] target_q;
   logic [16:0] rem;
   logic [15:0] dq;
   logic [3:0]  cnt;

   logic [16:0] trial;
   logic [16:0] divisor;
   logic        ge;
   logic [16:0] rem_next;

   // dq starts holding the dividend bits not yet shifted into the remainder and
   // fills with quotient bits, MSB first, as the divider runs.
   always_comb begin
      trial    = {rem[15:0], dq[15]};
      divisor  = {2'b00, amp_q[14:0]};
      ge       = rem[16] | (trial >= divisor);
      rem_next = ge ? (trial - divisor) : trial;
   end

   assign busy = (state != IDLE);

   // A host write always wins: it updates coef, drops any computation and clears the flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         coef     <= COEF_RESET;
         done     <= 1'b0;
         sat      <= 1'b0;
         err      <= 1'b0;
         amp_q    <= 16'h0000;
         target_q <= 16'h0000;
         rem      <= 17'h00000;
         dq       <= 16'h0000;
         cnt      <= 4'h0;
      end else begin
         done <= 1'b0;
         if (coef_wr) begin
            coef  <= coef_wdat;
            state <= IDLE;
            sat   <= 1'b0;
            err   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     amp_q    <= amp;
                     target_q <= target;
                     sat      <= 1'b0;
                     err      <= 1'b0;
                     state    <= CHECK;
                  end
               end
               CHECK: begin
                  if ($signed(amp_q) < MIN_AMP_S) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else if ({1'b0, target_q} >= {amp_q, 1'b0}) begin
                     sat   <= 1'b1;
                     state <= DONE;
                  end else begin
                     // target < 2*amp guarantees target>>1 < amp, so 16 steps suffice
                     rem   <= {2'b00, target_q[15:1]};
                     dq    <= {target_q[0], 15'h0000};
                     cnt   <= 4'h0;
                     state <= DIV;
                  end
               end
               DIV: begin
                  rem <= rem_next;
                  dq  <= {dq[14:0], ge};
                  cnt <= cnt + 4'h1;
                  if (cnt == 4'hF) begin
                     state <= DONE;
                  end
               end
               DONE: begin
                  done <= 1'b1;
                  if (sat) begin
                     coef <= 16'hFFFF;
                  end else if (!err) begin
                     coef <= dq;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_normcoef_calc.sv
// Self-checking bench for normcoef_calc: directed vectors plus a random operand sweep,
// checked cycle by cycle against an arithmetic reference model.
module tb_normcoef_calc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] amp = 16'h0000;
   logic [15:0] target = 16'h0000;
   logic        coef_wr = 1'b0;
   logic [15:0] coef_wdat = 16'h0000;
   logic        busy;
   logic        done;
   logic        sat;
   logic        err;
   logic [15:0] coef;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Reference model state
   logic [15:0] modelCoef = 16'h8000;
   bit          expSat = 1'b0;
   bit          expErr = 1'b0;
   bit          pSat = 1'b0;
   bit          pErr = 1'b0;
   logic [15:0] pQ = 16'h0000;
   int          startCyc = 0;
   int          doneCyc = -1;
   bit          checkEn = 1'b0;
   bit          expDone;
   bit          expBusy;

   normcoef_calc dut (
      .clk(clk), .rst_n(rst_n), .start(start), .amp(amp), .target(target),
      .coef_wr(coef_wr), .coef_wdat(coef_wdat), .busy(busy), .done(done),
      .sat(sat), .err(err), .coef(coef)
   );

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void refModel(input logic [15:0] a, input logic [15:0] t,
                                    output bit e, output bit s, output logic [15:0] q);
      longint ai;
      longint ti;
      ai = longint'($signed(a));
      ti = longint'(t);
      e = 1'b0;
      s = 1'b0;
      q = 16'h0000;
      if (ai < 16) e = 1'b1;
      else if (ti >= 2 * ai) s = 1'b1;
      else q = 16'((ti * 32768) / ai);
   endfunction

   // Compare process: every cycle out of reset, outputs must match the model's schedule.
   always @(negedge clk) begin
      if (rst_n && checkEn) begin
         expDone = (cyc == doneCyc);
         if (expDone) begin
            if (pSat) modelCoef = 16'hFFFF;
            else if (!pErr) modelCoef = pQ;
            expSat = pSat;
            expErr = pErr;
         end
         expBusy = (cyc >= startCyc) && (cyc < doneCyc);
         checkOutput("done", done, expDone);
         checkOutput("busy", busy, expBusy);
         checkOutput("coef", coef, modelCoef);
         if (!expBusy) begin
            checkOutput("sat", sat, expSat);
            checkOutput("err", err, expErr);
         end
      end
   end

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] t);
      @(negedge clk);
      amp = a;
      target = t;
      start = 1'b1;
      refModel(a, t, pErr, pSat, pQ);
      startCyc = cyc + 1;
      doneCyc = startCyc + ((pErr || pSat) ? 2 : 18);
      @(negedge clk);
      start = 1'b0;
      amp = 16'($urandom);
      target = 16'($urandom);
   endtask

   task automatic waitDone(output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - startCyc;
            break;
         end
      end
   endtask

   task automatic writeCoef(input logic [15:0] d, input logic withStart);
      @(negedge clk);
      coef_wr = 1'b1;
      coef_wdat = d;
      start = withStart;
      amp = 16'h1000;
      target = 16'h1000;
      @(posedge clk);
      #1;
      modelCoef = d;
      doneCyc = -1;
      expSat = 1'b0;
      expErr = 1'b0;
      @(negedge clk);
      coef_wr = 1'b0;
      start = 1'b0;
   endtask

   task automatic runDirected(input string name, input logic [15:0] a, input logic [15:0] t,
                              input logic [15:0] c, input int l, input bit s, input bit e);
      int lat;
      applyStimulus(a, t);
      waitDone(lat);
      checkOutput({name, "_lat"}, lat, l);
      checkOutput({name, "_coef"}, coef, c);
      checkOutput({name, "_sat"}, sat, s);
      checkOutput({name, "_err"}, err, e);
   endtask

   task automatic midCycleReset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_coef", coef, 16'h8000);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_sat", sat, 0);
      checkOutput("rst_err", err, 0);
      modelCoef = 16'h8000;
      doneCyc = -1;
      expSat = 1'b0;
      expErr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      int lat;
      logic [15:0] a;
      logic [15:0] t;
      int hi;

      repeat (3) @(negedge clk);
      checkOutput("por_coef", coef, 16'h8000);
      checkOutput("por_busy", busy, 0);
      rst_n = 1'b1;
      checkEn = 1'b1;
      repeat (10) @(negedge clk);

      runDirected("unity", 16'h1000, 16'h1000, 16'h8000, 18, 0, 0);
      runDirected("frac",  16'h1000, 16'h0C00, 16'h6000, 18, 0, 0);
      runDirected("trunc", 16'd3000, 16'd1000, 16'h2AAA, 18, 0, 0);
      runDirected("satur", 16'h0800, 16'h1000, 16'hFFFF, 2, 1, 0);
      runDirected("zero",  16'h0000, 16'h1000, 16'hFFFF, 2, 0, 1);
      runDirected("neg",   16'hF000, 16'h1000, 16'hFFFF, 2, 0, 1);
      runDirected("below", 16'd15,   16'd10,   16'hFFFF, 2, 0, 1);
      runDirected("edge",  16'd16,   16'd31,   16'hF800, 18, 0, 0);

      // Start while busy is ignored; the first result must arrive untouched.
      applyStimulus(16'h1000, 16'h0C00);
      repeat (5) @(negedge clk);
      amp = 16'h0100;
      target = 16'h0050;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(lat);
      checkOutput("ignore_lat", lat, 18);
      checkOutput("ignore_coef", coef, 16'h6000);

      // Host write aborts a running division.
      applyStimulus(16'h1000, 16'h1000);
      repeat (5) @(negedge clk);
      writeCoef(16'h1234, 1'b0);
      checkOutput("wr_abort_coef", coef, 16'h1234);
      checkOutput("wr_abort_busy", busy, 0);
      repeat (25) @(negedge clk);

      writeCoef(16'h4000, 1'b1);
      checkOutput("collide_coef", coef, 16'h4000);
      checkOutput("collide_busy", busy, 0);
      repeat (5) @(negedge clk);

      runDirected("pre_rst", 16'd3000, 16'd1000, 16'h2AAA, 18, 0, 0);
      applyStimulus(16'h1000, 16'h0C00);
      repeat (5) @(negedge clk);
      midCycleReset();
      checkOutput("post_rst_coef", coef, 16'h8000);

      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 9))
            0: begin
               a = 16'($urandom);
               t = 16'($urandom);
            end
            1: begin
               a = 16'($urandom_range(0, 20));
               t = 16'($urandom);
            end
            2: begin
               a = 16'($urandom_range(16, 32767));
               hi = 2 * int'(a);
               t = (hi > 65535) ? 16'hFFFF : 16'($urandom_range(hi, 65535));
            end
            default: begin
               a = 16'($urandom_range(16, 32767));
               hi = 2 * int'(a) - 1;
               if (hi > 65535) hi = 65535;
               t = 16'($urandom_range(0, hi));
            end
         endcase
         applyStimulus(a, t);
         waitDone(lat);
         checkOutput("rand_lat", lat, (pErr || pSat) ? 2 : 18);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
